// File: rtl/util_axis_pkg.sv
// util_axis_pkg: shared state encoding and LFSR constants for the util_axis stream blocks.
package util_axis_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      CHECK = 2'd2,
      HALT  = 2'd3
   } state_t;
   // Fibonacci taps 16,15,13,4 mapped onto bits 15,14,12,3
   localparam logic [15:0] LFSR_TAPS         = 16'hD008;
   localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
endpackage

// File: rtl/util_lfsr16.sv
// util_lfsr16: 16-bit Fibonacci LFSR; a zero seed is replaced by 1 so the register never locks up.
module util_lfsr16
   import util_axis_pkg::*;
#(
   parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
   input  logic        aclk,
   input  logic        arstn,
   input  logic        enable,
   output logic [15:0] lfsr
);
   localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) lfsr <= INIT;
      else if (enable) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   end
endmodule

// File: rtl/util_axis_seq_checker.sv
// util_axis_seq_checker: AXI-Stream sink checking tdata increments by one per beat, with beat/error counters.
// Define UTIL_AXIS_SEQ_CHECKER_RAND_READY_EN to drive tready from an LFSR for random backpressure.
module util_axis_seq_checker
   import util_axis_pkg::*;
#(
   parameter int          BUS_WIDTH   = 1,
   parameter int          CNT_WIDTH   = 32,
   parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED,
   parameter int          STOP_ON_ERR = 0
) (
   input  logic                   aclk,
   input  logic                   arstn,
   input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   input  logic                   enable,
   input  logic                   clr,
   output logic                   locked,
   output logic                   err,
   output logic                   halted,
   output logic [CNT_WIDTH-1:0]   beat_count,
   output logic [CNT_WIDTH-1:0]   err_count
);
   localparam int DW = BUS_WIDTH*8;
   state_t        state, nxt;
   logic [DW-1:0] expected;
   logic          xfer, mism, rdy;
`ifdef UTIL_AXIS_SEQ_CHECKER_RAND_READY_EN
   logic [15:0] lfsr;
   util_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .aclk   (aclk),
      .arstn  (arstn),
      .enable (state != IDLE),
      .lfsr   (lfsr)
   );
   assign rdy = lfsr[0];
`else
   logic unused_seed;
   assign unused_seed = ^LFSR_SEED;
   assign rdy = 1'b1;
`endif
   // tready is only high in SYNC/CHECK, so a transfer implies one of those states
   always_comb begin
      xfer = s_axis_tvalid & s_axis_tready;
      mism = xfer && state == CHECK && s_axis_tdata != expected;
      nxt  = !enable ? IDLE :
             clr ? SYNC :
             state == IDLE ? SYNC :
             state == SYNC ? (xfer ? CHECK : SYNC) :
             state == CHECK ? ((mism && STOP_ON_ERR != 0) ? HALT : CHECK) : HALT;
   end
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state         <= IDLE;
         s_axis_tready <= 1'b0;
         locked        <= 1'b0;
         err           <= 1'b0;
         halted        <= 1'b0;
         beat_count    <= '0;
         err_count     <= '0;
         expected      <= '0;
      end else begin
         state         <= nxt;
         s_axis_tready <= (nxt == SYNC || nxt == CHECK) & rdy;
         halted        <= nxt == HALT;
         if (clr) begin
            locked     <= 1'b0;
            err        <= 1'b0;
            beat_count <= '0;
            err_count  <= '0;
         end else begin
            err    <= mism;
            locked <= enable & (locked | (xfer & state == SYNC));
            if (xfer) begin
               beat_count <= beat_count + 1'b1;
               expected   <= s_axis_tdata + 1'b1;
            end
            if (mism && !(&err_count)) err_count <= err_count + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_util_axis_seq_checker.sv
// tb_util_axis_seq_checker: directed self-checking bench; three instances cover default, STOP_ON_ERR and a narrow counter.
module tb_util_axis_seq_checker;
   logic        tb_data_clk = 1'b0;
   logic        arstn = 1'b1;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        enable = 1'b0;
   logic        clr = 1'b0;
   logic        s_axis_tready, locked, err, halted;
   logic [31:0] beat_count, err_count;
   logic        tready_h, locked_h, err_h, halted_h;
   logic [31:0] beat_count_h, err_count_h;
   logic        tready_s, locked_s, err_s, halted_s;
   logic [1:0]  beat_count_s, err_count_s;
   int          checks = 0;
   int          errors = 0;
   int          err_seen = 0;

   always #5 tb_data_clk = ~tb_data_clk;

   util_axis_seq_checker dut (
      .aclk(tb_data_clk), .arstn(arstn), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .enable(enable), .clr(clr), .locked(locked), .err(err),
      .halted(halted), .beat_count(beat_count), .err_count(err_count)
   );
   util_axis_seq_checker #(.STOP_ON_ERR(1)) dut_h (
      .aclk(tb_data_clk), .arstn(arstn), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(tready_h), .enable(enable), .clr(clr), .locked(locked_h), .err(err_h),
      .halted(halted_h), .beat_count(beat_count_h), .err_count(err_count_h)
   );
   util_axis_seq_checker #(.CNT_WIDTH(2)) dut_s (
      .aclk(tb_data_clk), .arstn(arstn), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(tready_s), .enable(enable), .clr(clr), .locked(locked_s), .err(err_s),
      .halted(halted_s), .beat_count(beat_count_s), .err_count(err_count_s)
   );

   task automatic tick();
      @(posedge tb_data_clk);
      #1;
   endtask

   task automatic pulse_clr();
      @(negedge tb_data_clk);
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic beat(input logic [7:0] d);
      int n = 0;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      @(negedge tb_data_clk);
      while (!s_axis_tready && n < 64) begin
         n++;
         @(negedge tb_data_clk);
      end
      if (!s_axis_tready) begin
         checks++; errors++;
         $display("FAIL beat_timeout tready=%0b required 1 for data %0h", s_axis_tready, d);
         s_axis_tvalid = 1'b0;
         return;
      end
      tick();
      s_axis_tvalid = 1'b0;
      err_seen += int'(err);
   endtask

   task automatic test_reset();
      #2 arstn = 1'b0;
      #20;
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %0b exp 0", s_axis_tready); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %0b exp 0", locked); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err); end
      checks++; if (halted_h !== 1'b0) begin errors++; $display("FAIL rst_halted got %0b exp 0", halted_h); end
      checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL rst_beat_count got %0d exp 0", beat_count); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL rst_err_count got %0d exp 0", err_count); end
      @(negedge tb_data_clk);
      arstn  = 1'b1;
      enable = 1'b1;
      tick();
`ifndef UTIL_AXIS_SEQ_CHECKER_RAND_READY_EN
      checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL sync_tready got %0b exp 1", s_axis_tready); end
`endif
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL sync_locked got %0b exp 0", locked); end
   endtask

   task automatic test_count();
      err_seen = 0;
      for (int i = 0; i < 300; i++) begin
         beat(8'(i));
         if (i == 0) begin
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL count_locked got %0b exp 1", locked); end
         end
      end
      checks++; if (err_seen !== 0) begin errors++; $display("FAIL count_err_pulses got %0d exp 0", err_seen); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL count_err_count got %0d exp 0", err_count); end
      checks++; if (beat_count !== 32'd300) begin errors++; $display("FAIL count_beat_count got %0d exp 300", beat_count); end
   endtask

   task automatic test_mismatch();
      logic [7:0] v [6] = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd9};
      pulse_clr();
      checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL clr_beat_count got %0d exp 0", beat_count); end
      for (int i = 0; i < 6; i++) begin
         beat(v[i]);
         checks++; if (err !== (i == 3)) begin errors++; $display("FAIL mism_err_beat%0d got %0b exp %0b", i, err, i == 3); end
      end
      checks++; if (err_count !== 32'd1) begin errors++; $display("FAIL mism_err_count got %0d exp 1", err_count); end
      checks++; if (beat_count !== 32'd6) begin errors++; $display("FAIL mism_beat_count got %0d exp 6", beat_count); end
      checks++; if (halted_h !== 1'b1) begin errors++; $display("FAIL mism_halted_h got %0b exp 1", halted_h); end
      checks++; if (beat_count_h !== 32'd4) begin errors++; $display("FAIL mism_beat_count_h got %0d exp 4", beat_count_h); end
   endtask

   task automatic test_saturate();
      logic [7:0] v [5] = '{8'd0, 8'd5, 8'd9, 8'd20, 8'd30};
      pulse_clr();
      for (int i = 0; i < 5; i++) beat(v[i]);
      checks++; if (err_count !== 32'd4) begin errors++; $display("FAIL sat_err_count got %0d exp 4", err_count); end
      checks++; if (err_count_s !== 2'd3) begin errors++; $display("FAIL sat_err_count_s got %0d exp 3", err_count_s); end
      checks++; if (beat_count_s !== 2'd1) begin errors++; $display("FAIL wrap_beat_count_s got %0d exp 1", beat_count_s); end
   endtask

   task automatic test_stop();
      pulse_clr();
      beat(8'd0);
      beat(8'd1);
      beat(8'd5);
      checks++; if (halted_h !== 1'b1) begin errors++; $display("FAIL stop_halted got %0b exp 1", halted_h); end
      checks++; if (tready_h !== 1'b0) begin errors++; $display("FAIL stop_tready got %0b exp 0", tready_h); end
      s_axis_tvalid = 1'b1;
      repeat (3) tick();
      s_axis_tvalid = 1'b0;
      checks++; if (halted_h !== 1'b1) begin errors++; $display("FAIL stop_hold_halted got %0b exp 1", halted_h); end
      checks++; if (beat_count_h !== 32'd3) begin errors++; $display("FAIL stop_hold_beats got %0d exp 3", beat_count_h); end
      checks++; if (err_count_h !== 32'd1) begin errors++; $display("FAIL stop_err_count got %0d exp 1", err_count_h); end
      pulse_clr();
      checks++; if (halted_h !== 1'b0) begin errors++; $display("FAIL stop_clr_halted got %0b exp 0", halted_h); end
`ifndef UTIL_AXIS_SEQ_CHECKER_RAND_READY_EN
      checks++; if (tready_h !== 1'b1) begin errors++; $display("FAIL stop_clr_tready got %0b exp 1", tready_h); end
`endif
      checks++; if (beat_count_h !== 32'd0) begin errors++; $display("FAIL stop_clr_beats got %0d exp 0", beat_count_h); end
      checks++; if (err_count_h !== 32'd0) begin errors++; $display("FAIL stop_clr_errs got %0d exp 0", err_count_h); end
   endtask

   task automatic test_enable();
      pulse_clr();
      for (int i = 0; i < 10; i++) beat(8'(i));
      enable = 1'b0;
      tick();
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL dis_tready got %0b exp 0", s_axis_tready); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL dis_locked got %0b exp 0", locked); end
      repeat (3) tick();
      checks++; if (beat_count !== 32'd10) begin errors++; $display("FAIL dis_beat_count got %0d exp 10", beat_count); end
      enable   = 1'b1;
      err_seen = 0;
      for (int i = 0; i < 5; i++) beat(8'(8'h40 + i));
      checks++; if (err_seen !== 0) begin errors++; $display("FAIL reen_err_pulses got %0d exp 0", err_seen); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL reen_err_count got %0d exp 0", err_count); end
      checks++; if (beat_count !== 32'd15) begin errors++; $display("FAIL reen_beat_count got %0d exp 15", beat_count); end
   endtask

   task automatic test_clr_xfer();
      int n = 0;
      @(negedge tb_data_clk);
      while (!s_axis_tready && n < 64) begin
         n++;
         @(negedge tb_data_clk);
      end
      s_axis_tdata  = 8'h99;
      s_axis_tvalid = 1'b1;
      clr           = 1'b1;
      tick();
      clr           = 1'b0;
      s_axis_tvalid = 1'b0;
      checks++; if (beat_count !== 32'd0) begin errors++; $display("FAIL clrx_beat_count got %0d exp 0", beat_count); end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clrx_locked got %0b exp 0", locked); end
      err_seen = 0;
      beat(8'h10);
      beat(8'h11);
      checks++; if (err_seen !== 0) begin errors++; $display("FAIL clrx_err_pulses got %0d exp 0", err_seen); end
      checks++; if (beat_count !== 32'd2) begin errors++; $display("FAIL clrx_beat_count2 got %0d exp 2", beat_count); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clrx_locked2 got %0b exp 1", locked); end
   endtask

   task automatic test_ready();
      int hi = 0, hrun = 0, lrun = 0, maxh = 0, maxl = 0;
      logic took;
      pulse_clr();
      s_axis_tdata  = 8'h00;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge tb_data_clk);
         took = s_axis_tready;
         if (took) begin hi++; hrun++; lrun = 0; end
         else begin lrun++; hrun = 0; end
         maxh = (hrun > maxh) ? hrun : maxh;
         maxl = (lrun > maxl) ? lrun : maxl;
         tick();
         if (took) s_axis_tdata = s_axis_tdata + 8'd1;
      end
      s_axis_tvalid = 1'b0;
      tick();
      checks++; if (beat_count !== 32'(hi)) begin errors++; $display("FAIL rdy_beat_count got %0d exp %0d", beat_count, hi); end
      checks++; if (err_count !== 32'd0) begin errors++; $display("FAIL rdy_err_count got %0d exp 0", err_count); end
`ifdef UTIL_AXIS_SEQ_CHECKER_RAND_READY_EN
      checks++; if (maxh > 16) begin errors++; $display("FAIL rdy_high_run got %0d exp <=16", maxh); end
      checks++; if (maxl > 16) begin errors++; $display("FAIL rdy_low_run got %0d exp <=16", maxl); end
`else
      checks++; if (hi !== 1000) begin errors++; $display("FAIL rdy_const_high got %0d exp 1000", hi); end
      checks++; if (maxl !== 0) begin errors++; $display("FAIL rdy_low_run got %0d exp 0", maxl); end
`endif
   endtask

   initial begin
      test_reset();
      test_count();
      test_mismatch();
      test_saturate();
      test_stop();
      test_enable();
      test_clr_xfer();
      test_ready();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
